// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped 64-bit timer/compare block:
// base address, register word offsets, CTRL/STATUS bit positions, lane merge.
package mmio_timer_pkg;

    localparam logic [31:0] TIMER_BASE = 32'hFF20_0500;

    // Register offsets expressed as word index, i.e. DwAddress[4:2]
    typedef enum logic [2:0] {
        OFS_MTIME_LO = 3'd0,
        OFS_MTIME_HI = 3'd1,
        OFS_CMP_LO   = 3'd2,
        OFS_CMP_HI   = 3'd3,
        OFS_CTRL     = 3'd4,
        OFS_STATUS   = 3'd5
    } reg_e;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_IE     = 1;
    localparam int STATUS_PEND = 0;

    typedef struct packed {
        logic ie;
        logic en;
    } ctrl_t;

    // Replace only the byte lanes selected by be
    function automatic logic [31:0] merge_be(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/mmio_timer_prescaler.sv
// Divides iCLK down to a one-cycle tick every TICK_DIV cycles while enabled;
// the phase is held at zero whenever counting is disabled.
module timer_prescaler #(
    parameter int TICK_DIV = 50
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iEN,
    output logic oTick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign oTick = iEN && (cnt == LAST);

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST)
            cnt <= '0;
        else if (!iEN || oTick)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/mmio_timer.sv
// 64-bit mtime/mtimecmp timer on the Dw* data bus with a sticky compare
// pending flag, zero-wait-state reads and a registered level interrupt.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = TIMER_BASE,
    parameter int          TICK_DIV  = 50
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        DwReadEnable,
    input  logic        DwWriteEnable,
    input  logic [3:0]  DwByteEnable,
    input  logic [31:0] DwAddress,
    input  logic [31:0] DwWriteData,
    output logic [31:0] DwReadData,
    output logic        oIRQ
);

    logic        sel, wr, rd, tick, match, w1c;
    reg_e        ofs;
    logic [63:0] mtime, mtime_nxt;
    logic [63:0] mtimecmp, cmp_nxt;
    logic [31:0] shadow_hi, shadow_nxt;
    ctrl_t       ctrl, ctrl_nxt;
    logic        pending, pend_nxt;
    logic        unused_addr;

    assign unused_addr = ^DwAddress[1:0];

    assign ofs   = reg_e'(DwAddress[4:2]);
    assign sel   = (DwAddress[31:5] == BASE_ADDR[31:5]) && (DwAddress[4:2] <= 3'd5);
    assign wr    = DwWriteEnable && sel;
    assign rd    = DwReadEnable && sel;
    assign match = ctrl.en && (mtime >= mtimecmp);
    assign w1c   = wr && (ofs == OFS_STATUS) && DwByteEnable[0] && DwWriteData[STATUS_PEND];

    timer_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iEN   (ctrl.en),
        .oTick (tick)
    );

    // A bus write to either mtime half replaces the tick result for the full
    // 64 bits, so the untouched half keeps its pre-increment value.
    always_comb begin
        mtime_nxt  = tick ? mtime + 64'd1 : mtime;
        cmp_nxt    = mtimecmp;
        ctrl_nxt   = ctrl;
        shadow_nxt = shadow_hi;
        pend_nxt   = pending;

        if (match)
            pend_nxt = 1'b1;
        else if (w1c)
            pend_nxt = 1'b0;

        if (rd && (ofs == OFS_MTIME_LO))
            shadow_nxt = mtime[63:32];

        if (wr) begin
            case (ofs)
                OFS_MTIME_LO: mtime_nxt = {mtime[63:32],
                                           merge_be(mtime[31:0], DwWriteData, DwByteEnable)};
                OFS_MTIME_HI: mtime_nxt = {merge_be(mtime[63:32], DwWriteData, DwByteEnable),
                                           mtime[31:0]};
                OFS_CMP_LO:   cmp_nxt[31:0]  = merge_be(mtimecmp[31:0], DwWriteData, DwByteEnable);
                OFS_CMP_HI:   cmp_nxt[63:32] = merge_be(mtimecmp[63:32], DwWriteData, DwByteEnable);
                OFS_CTRL: begin
                    if (DwByteEnable[0]) begin
                        ctrl_nxt.en = DwWriteData[CTRL_EN];
                        ctrl_nxt.ie = DwWriteData[CTRL_IE];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            mtime     <= '0;
            mtimecmp  <= '1;
            shadow_hi <= '0;
            ctrl      <= '0;
            pending   <= 1'b0;
            oIRQ      <= 1'b0;
        end else begin
            mtime     <= mtime_nxt;
            mtimecmp  <= cmp_nxt;
            shadow_hi <= shadow_nxt;
            ctrl      <= ctrl_nxt;
            pending   <= pend_nxt;
            oIRQ      <= pending & ctrl.ie;
        end
    end

    // Reads see pre-edge register values, so a same-cycle write is not visible yet
    always_comb begin
        DwReadData = '0;
        if (rd) begin
            case (ofs)
                OFS_MTIME_LO: DwReadData = mtime[31:0];
                OFS_MTIME_HI: DwReadData = shadow_hi;
                OFS_CMP_LO:   DwReadData = mtimecmp[31:0];
                OFS_CMP_HI:   DwReadData = mtimecmp[63:32];
                OFS_CTRL: begin
                    DwReadData[CTRL_EN] = ctrl.en;
                    DwReadData[CTRL_IE] = ctrl.ie;
                end
                OFS_STATUS:   DwReadData[STATUS_PEND] = pending;
                default: ;
            endcase
        end
    end

endmodule
